counter_param: RTL

- Parametrised successor of the fixed 32-bit four-mode counter.
- Width, up-step and down-step are parameters; wrap or saturate behaviour is selectable by parameter.
- Adds a registered compare-match output and a sticky overflow flag.
- Used as the DUV for the next round of counter benches and as the common counter primitive elsewhere in the design.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_step_alu.sv | 50 +++++
 rtl/counter_param.sv | 86 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised counter: mode encoding and default steps.
package counter_pkg;

    typedef enum logic [1:0] {
        MODO_UP  = 2'b00,
        MODO_DN1 = 2'b01,
        MODO_DNS = 2'b10,
        MODO_LD  = 2'b11
    } modo_e;

    localparam int WIDTH_DEF   = 32;
    localparam int STEP_UP_DEF = 1;
    localparam int STEP_DN_DEF = 3;

endpackage

// File: rtl/counter_step_alu.sv
// Combinational next-count logic: applies the mode step to q and flags a
// wrap/clamp event. Mode 11 passes q through; the top substitutes D.
module counter_step_alu
    import counter_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int STEP_UP  = STEP_UP_DEF,
    parameter int STEP_DN  = STEP_DN_DEF,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       modo,
    output logic [WIDTH-1:0] nxt,
    output logic             evt
);

    localparam logic [WIDTH-1:0] UP_W  = WIDTH'(STEP_UP);
    localparam logic [WIDTH-1:0] DN_W  = WIDTH'(STEP_DN);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_W = '1;
    localparam bit               SAT   = (SATURATE != 0);

    // One extra bit catches the carry out of the increment.
    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, q} + {1'b0, UP_W};
        nxt = q;
        evt = 1'b0;
        case (modo_e'(modo))
            MODO_UP: begin
                evt = sum[WIDTH];
                nxt = (evt && SAT) ? MAX_W : sum[WIDTH-1:0];
            end
            MODO_DN1: begin
                evt = (q == '0);
                nxt = (evt && SAT) ? '0 : q - ONE_W;
            end
            MODO_DNS: begin
                evt = (q < DN_W);
                nxt = (evt && SAT) ? '0 : q - DN_W;
            end
            default: begin
                nxt = q;
                evt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/counter_param.sv
// Parametrised four-mode counter with registered event pulse, load pulse,
// compare match and sticky overflow flag.
module counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int STEP_UP  = STEP_UP_DEF,
    parameter int STEP_DN  = STEP_DN_DEF,
    parameter int SATURATE = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] CMP,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             LOAD,
    output logic             MATCH,
    output logic             OVF
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic             load_q, load_d;
    logic             match_q, match_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] alu_nxt;
    logic             alu_evt;

    counter_step_alu #(
        .WIDTH   (WIDTH),
        .STEP_UP (STEP_UP),
        .STEP_DN (STEP_DN),
        .SATURATE(SATURATE)
    ) u_alu (
        .q   (q_q),
        .modo(MODO),
        .nxt (alu_nxt),
        .evt (alu_evt)
    );

    always_comb begin
        q_d    = q_q;
        rco_d  = 1'b0;
        load_d = 1'b0;
        ovf_d  = ovf_q;
        if (ENABLE) begin
            if (modo_e'(MODO) == MODO_LD) begin
                q_d    = D;
                load_d = 1'b1;
                ovf_d  = 1'b0;
            end else begin
                q_d   = alu_nxt;
                rco_d = alu_evt;
                ovf_d = ovf_q | alu_evt;
            end
        end
        // Match tracks the value about to be registered, so it also follows a held Q.
        match_d = (q_d == CMP);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_q     <= '0;
            rco_q   <= 1'b0;
            load_q  <= 1'b0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            rco_q   <= rco_d;
            load_q  <= load_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Q     = q_q;
    assign RCO   = rco_q;
    assign LOAD  = load_q;
    assign MATCH = match_q;
    assign OVF   = ovf_q;

endmodule
